// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline stall controller.
package pipe_ctrl_pkg;
   localparam int REG_W = 5;
   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      ST_HALT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_MEMWAIT = 2'd2,
      ST_STEP    = 2'd3
   } state_e;
endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: EX load writing a register the ID instruction reads.
module hazard_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_mem_read_i,
   input  logic [REG_W-1:0] ex_rd_i,
   input  logic [REG_W-1:0] id_rs1_i,
   input  logic [REG_W-1:0] id_rs2_i,
   input  logic             id_uses_rs1_i,
   input  logic             id_uses_rs2_i,
   output logic             load_use_o
);
   logic hit1, hit2;

   assign hit1       = id_uses_rs1_i && (id_rs1_i == ex_rd_i);
   assign hit2       = id_uses_rs2_i && (id_rs2_i == ex_rd_i);
   // x0 is hardwired zero, so a load "to" it never creates a dependency.
   assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (hit1 || hit2);
endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Run/halt/step FSM with memory, branch and load-use stall control for a 5-stage pipe.
// Optional single-step mode enabled by defining PIPE_SINGLE_STEP_EN.
module pipeline_stall_ctrl
   import pipe_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic             step_req,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic             ex_mem_read,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] stall_cnt
);
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_use, active, mem_stall;

`ifndef PIPE_SINGLE_STEP_EN
   logic unused_step_req;
   assign unused_step_req = step_req;
`endif

   hazard_detect u_hazard (
      .ex_mem_read_i (ex_mem_read),
      .ex_rd_i       (ex_rd),
      .id_rs1_i      (id_rs1),
      .id_rs2_i      (id_rs2),
      .id_uses_rs1_i (id_uses_rs1),
      .id_uses_rs2_i (id_uses_rs2),
      .load_use_o    (load_use)
   );

   assign active    = (state_q != ST_HALT) && !rst;
   // While waiting, completion alone releases the pipe; elsewhere only a pending access stalls.
   assign mem_stall = (state_q == ST_MEMWAIT) ? !mem_ready : (mem_req && !mem_ready);

   always_comb begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (active && !mem_stall) begin
         pc_en    = 1'b1;
         ifid_en  = 1'b1;
         idex_en  = 1'b1;
         exmem_en = 1'b1;
         memwb_en = 1'b1;
         if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
         end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_HALT: begin
            if (run)
               state_d = ST_RUN;
`ifdef PIPE_SINGLE_STEP_EN
            else if (step_req)
               state_d = ST_STEP;
`endif
         end
         ST_RUN, ST_MEMWAIT: begin
            if (mem_stall)
               state_d = ST_MEMWAIT;
            else
               state_d = run ? ST_RUN : ST_HALT;
         end
         ST_STEP: state_d = mem_stall ? ST_MEMWAIT : ST_HALT;
         default: state_d = ST_HALT;
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (active && !pc_en && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_HALT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign state     = state_q;
   assign stall_cnt = cnt_q;
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed + randomized check of pipeline_stall_ctrl against a rule-level reference model.
module tb_pipeline_stall_ctrl;
   logic        clk = 1'b0;
   logic        rst, run, step_req;
   logic [4:0]  id_rs1, id_rs2, ex_rd;
   logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken;
   logic        mem_req, mem_ready;
   logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
   logic [1:0]  state;
   logic [15:0] stall_cnt;

   int n_chk  = 0;
   int n_pass = 0;
   int m_state = 0;
   int m_cnt   = 0;
   logic [6:0] exp_vec;

   always #5 clk = ~clk;

   pipeline_stall_ctrl dut (
      .clk(clk), .rst(rst), .run(run), .step_req(step_req),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
      .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_branch_taken(ex_branch_taken),
      .mem_req(mem_req), .mem_ready(mem_ready),
      .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
      .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
      .state(state), .stall_cnt(stall_cnt)
   );

   wire [6:0] out_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_chk++;
      if (obs === exp_v) n_pass++;
      else $display("FAIL %s got %0h expected %0h", tag, obs, exp_v);
   endtask

   // Expected outputs from the spec's priority rules, given model state and current inputs.
   function automatic logic [6:0] model_out();
      bit haz, stall;
      if (rst || m_state == 0) return 7'b0;
      stall = (m_state == 2) ? !mem_ready : (mem_req && !mem_ready);
      haz   = ex_mem_read && ex_rd != 0 &&
              ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
      if (stall)           return 7'b0000000;
      if (ex_branch_taken) return 7'b1111111;
      if (haz)             return 7'b0011101;
      return 7'b1111100;
   endfunction

   task automatic model_step(input logic [6:0] o);
      bit stall;
      if (rst) begin
         m_state = 0; m_cnt = 0; return;
      end
      stall = (m_state == 2) ? !mem_ready : (mem_req && !mem_ready);
      if (m_state != 0 && !o[6] && m_cnt < 16'hFFFF) m_cnt++;
      case (m_state)
         0: begin
`ifdef PIPE_SINGLE_STEP_EN
            m_state = run ? 1 : (step_req ? 3 : 0);
`else
            m_state = run ? 1 : 0;
`endif
         end
         1, 2: m_state = stall ? 2 : (run ? 1 : 0);
         default: m_state = stall ? 2 : 0;
      endcase
   endtask

   // Inputs already applied; settle, compare with model, clock, advance model.
   task automatic tick();
      #1;
      exp_vec = model_out();
      chk("state", 32'(state), 32'(m_state));
      chk("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
      chk("enables", 32'(out_vec), 32'(exp_vec));
      @(posedge clk);
      model_step(exp_vec);
      #1;
   endtask

   task automatic idle_inputs();
      step_req = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
      ex_mem_read = 0; ex_rd = 0; ex_branch_taken = 0; mem_req = 0; mem_ready = 0;
   endtask

   initial begin
      rst = 1; run = 0; idle_inputs();
      @(posedge clk); #1;
      tick(); tick();
      chk("rst_state", 32'(state), 0);
      chk("rst_en", 32'(out_vec), 0);
      rst = 0;

      // Reset release then run: HALT -> RUN, full advance.
      run = 1; tick();
      #1 chk("run_state", 32'(state), 1);
      chk("run_en", 32'(out_vec), 32'(7'b1111100));
      chk("run_cnt", 32'(stall_cnt), 0);
      tick();

      // Load-use on rs2.
      ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
      #1 chk("lu_en", 32'(out_vec), 32'(7'b0011101));
      tick();
      chk("lu_cnt", 32'(stall_cnt), 1);
      ex_rd = 0;
      #1 chk("lu_x0", 32'(out_vec), 32'(7'b1111100));
      tick();

      // Branch overrides load-use.
      ex_rd = 5; ex_branch_taken = 1;
      #1 chk("br_en", 32'(out_vec), 32'(7'b1111111));
      tick();
      chk("br_cnt", 32'(stall_cnt), 1);
      idle_inputs();

      // Three-cycle memory wait.
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 3; i++) begin
         #1 chk("mw_en", 32'(out_vec), 0);
         tick();
      end
      chk("mw_state", 32'(state), 2);
      chk("mw_cnt", 32'(stall_cnt), 4);
      mem_ready = 1;
      #1 chk("mw_done_en", 32'(out_vec), 32'(7'b1111100));
      tick();
      chk("mw_done_state", 32'(state), 1);
      idle_inputs();

      // Halt, then single-step request.
      run = 0; tick();
      step_req = 1; tick();
      step_req = 0;
`ifdef PIPE_SINGLE_STEP_EN
      chk("step_state", 32'(state), 3);
      #1 chk("step_en", 32'(out_vec), 32'(7'b1111100));
      tick();
      chk("step_back", 32'(state), 0);
`else
      chk("step_ignored", 32'(state), 0);
      #1 chk("step_en", 32'(out_vec), 0);
      tick();
`endif

      // Randomized phase.
      for (int i = 0; i < 600; i++) begin
         rst         = ($urandom_range(0, 60) == 0);
         run         = ($urandom_range(0, 3) != 0);
         step_req    = ($urandom_range(0, 5) == 0);
         id_rs1      = 5'($urandom_range(0, 3));
         id_rs2      = 5'($urandom_range(0, 3));
         ex_rd       = 5'($urandom_range(0, 3));
         id_uses_rs1 = 1'($urandom);
         id_uses_rs2 = 1'($urandom);
         ex_mem_read = 1'($urandom);
         ex_branch_taken = ($urandom_range(0, 4) == 0);
         mem_req     = ($urandom_range(0, 2) == 0);
         mem_ready   = 1'($urandom);
         tick();
      end

      // Counter saturation.
      rst = 1; run = 1; idle_inputs();
      tick();
      rst = 0; tick();
      mem_req = 1; mem_ready = 0;
      for (int i = 0; i < 32'hFFFE + 5; i++) @(posedge clk);
      #1 chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
      chk("sat_state", 32'(state), 2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/pipeline_stall_ctrl.md
PIPELINE_STALL_CTRL -- requirements
Module: pipeline_stall_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-002 SHALL have run  in  1  level; 1 = free-run pipeline, 0 = halt request.
REQ-003 SHALL have step_req  in  1  single-cycle pulse; advances pipeline one cycle while halted.
REQ-004 SHALL have id_rs1, id_rs2  in  5 each  ID-stage source register numbers; id_uses_rs1, id_uses_rs2  in  1 each  source-valid flags.
REQ-005 SHALL have ex_mem_read  in  1  EX instruction is a load; ex_rd  in  5  EX destination register.
REQ-006 SHALL have ex_branch_taken  in  1  taken branch/jump resolved in EX.
REQ-007 SHALL have mem_req  in  1  MEM stage accessing data memory; mem_ready  in  1  data memory completes this cycle.
REQ-008 SHALL have pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  per-register advance enables (cpu_en of each pipeline register).
REQ-009 SHALL have ifid_flush, idex_flush  out  1 each  load-bubble into that register.
REQ-010 SHALL have state  out  2  FSM state (HALT=0, RUN=1, MEMWAIT=2, STEP=3); stall_cnt  out  16  stall-cycle counter.

Function
REQ-011 SHALL implement FSM HALT/RUN/MEMWAIT/STEP; enables and flushes combinational from state and current inputs; state and stall_cnt registered.
REQ-012 HALT: all enables 0, flushes 0; run=1 -> RUN next cycle; run=0 and step_req=1 -> STEP; run and step_req both 1 -> RUN.
REQ-013 RUN: run=0 -> HALT next cycle, enables still evaluated normally in the current cycle.
REQ-014 Memory stall: in RUN/STEP/MEMWAIT with mem_req=1, mem_ready=0 -> all five enables 0, flushes 0; next state MEMWAIT.
REQ-015 MEMWAIT: enables 0 until mem_ready=1; in that cycle enables evaluated as RUN; next state RUN if run=1, else HALT; run is ignored while waiting.
REQ-016 Load-use: ex_mem_read=1, ex_rd!=0, and (id_uses_rs1 and id_rs1==ex_rd, or id_uses_rs2 and id_rs2==ex_rd) -> pc_en=0, ifid_en=0, idex_flush=1, idex_en/exmem_en/memwb_en=1; exactly one bubble per hazard.
REQ-017 Branch: ex_branch_taken=1 -> all enables 1, ifid_flush=1, idex_flush=1.
REQ-018 Priority: memory stall > branch > load-use > normal advance (all enables 1, flushes 0).
REQ-019 STEP: evaluate exactly as RUN for one cycle, then HALT; memory stall in STEP -> MEMWAIT, then HALT on completion if run=0.
REQ-020 stall_cnt SHALL increment by 1 each cycle pc_en=0 while state!=HALT, saturating at 0xFFFF.

Reset
REQ-021 rst=1 SHALL force state=HALT, stall_cnt=0; all enables and flushes 0 while rst=1.
REQ-022 rst mid-MEMWAIT or mid-STEP SHALL abandon the operation with no further enable pulse.

Configuration
REQ-023 Macro PIPE_SINGLE_STEP_EN: defined -> STEP state and step_req behave per REQ-012/019.
REQ-024 Not defined -> step_req port present but ignored, STEP unreachable, state never 3.

Structure
REQ-025 Shared package pipe_ctrl_pkg SHALL hold state enum, register-number width (5), stall_cnt width (16).
REQ-026 Load-use comparison SHALL be one combinational sub-module hazard_detect; FSM, enable logic, counter in top.

Verification
REQ-027 Reset then run=1: state 0 -> 1 next cycle, all enables 1, stall_cnt=0.
REQ-028 ex_mem_read=1, ex_rd=5, id_rs2=5, id_uses_rs2=1: pc_en=ifid_en=0, idex_flush=1 for one cycle; stall_cnt=1; ex_rd=0 same case -> no stall.
REQ-029 ex_branch_taken=1 with load-use active: both flushes 1, pc_en=1, stall_cnt unchanged.
REQ-030 mem_req=1, mem_ready=0 for 3 cycles then 1: enables 0 for 3 cycles, state 2, stall_cnt=3, then advance and state 1.
REQ-031 Macro defined, run=0, step_req pulse: exactly one cycle all enables 1, state 3 -> 0; macro undefined: no enables, state stays 0.
REQ-032 Force 0xFFFE stall cycles plus 5: stall_cnt holds 0xFFFF.
